arbitro_mux_4: RTL
==================

ARBITRO_MUX_4 -- requirements
Module: arbitro_mux_4

Interface
REQ-001 Parameter n, default 4: data width of each requester channel and of the output.
REQ-002 Parameter MAX_BEAT, default 8: maximum transfers per grant; legal range 1..15.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  4  request per requester; bit k belongs to requester k.
REQ-006 i_Datos_0..i_Datos_3  input  n each  data from requesters 0..3.
REQ-007 i_ready  input  1  downstream consumer accepts o_Datos this cycle.
REQ-008 o_gnt  output  4  one-hot grant, all-zero when idle.
REQ-009 o_sel  output  2  index of granted requester, driven to the shared 4:1 selector.
REQ-010 o_Datos  output  n  selected data.
REQ-011 o_valid  output  1  o_Datos holds a valid beat this cycle.
REQ-012 o_ack  output  4  one-hot pulse to requester k when its beat transfers.

Function
REQ-013 Two states SHALL exist: IDLE and GRANT.
REQ-014 IDLE: o_gnt=0, o_valid=0, o_ack=0, o_Datos=0; o_sel holds its last value.
REQ-015 IDLE with i_req!=0: winner = first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4); next cycle state=GRANT, o_sel=winner, o_gnt=one-hot(winner), ptr=winner, beat count=0.
REQ-016 Arbitration latency SHALL be exactly one cycle: request sampled at edge t, grant visible after edge t+1.
REQ-017 IDLE with i_req=0: remain IDLE, ptr unchanged.
REQ-018 GRANT: o_valid = i_req[o_sel]; o_Datos = i_Datos_<o_sel> combinationally.
REQ-019 Transfer occurs in a cycle where o_valid=1 and i_ready=1; o_ack[o_sel]=1 in that cycle only; beat count increments by 1.
REQ-020 o_valid=1, i_ready=0: grant, o_Datos selection and count held; no ack.
REQ-021 Release on i_req[o_sel]=0 (no transfer that cycle) or on a transfer making count equal MAX_BEAT; next state IDLE, o_gnt cleared.
REQ-022 After every release one IDLE cycle SHALL occur before any new grant (dead cycle).
REQ-023 Requests of non-granted requesters SHALL not affect GRANT state.
REQ-024 A requester that keeps requesting after release SHALL be served again only after every other active requester (round-robin fairness).
REQ-025 Beat counter width 4 bits; never exceeds MAX_BEAT; no wrap-around.
REQ-026 o_gnt and o_sel SHALL be registered; o_valid, o_ack, o_Datos are combinational from registered state and inputs.

Reset
REQ-027 i_rst=1 at an edge: state=IDLE, o_gnt=0, o_sel=0, ptr=3 (requester 0 wins first), count=0.
REQ-028 Reset SHALL dominate all other inputs, including mid-grant; no ack or transfer is counted in a cycle with i_rst=1.
REQ-029 Outputs during and after reset follow REQ-014 until a request is arbitrated.

Structure
REQ-030 Shared package holds state encoding (IDLE=1'b0, GRANT=1'b1) and MAX_BEAT default constant.
REQ-031 Round-robin pick logic SHALL be one combinational sub-module rr_prioridad_4 (inputs: 4-bit request, 2-bit ptr; outputs: 2-bit index, found flag).
REQ-032 Data selection SHALL be a 4:1 case on o_sel with default to channel 3.

Verification
REQ-033 Reset, then i_req=4'b0001, i_ready=1, i_Datos_0=4'hA -> o_gnt=0001 one cycle later, o_Datos=4'hA, o_ack[0] pulses 8 cycles, release, one IDLE cycle.
REQ-034 i_req=4'b1111 held, i_ready=1 -> grant order 0,1,2,3,0, each 8 beats separated by one IDLE cycle.
REQ-035 Granted to 2, i_ready=0 for 3 cycles -> o_valid=1, no ack, count stays, o_Datos=i_Datos_2 stable.
REQ-036 Granted to 1, i_req[1] drops after 3 beats -> o_valid=0 that cycle, IDLE next, ptr=1, next grant goes to 2 if requesting.
REQ-037 i_rst asserted mid-grant after 5 beats -> next cycle IDLE, o_gnt=0, next grant to requester 0 with count=0.
REQ-038 MAX_BEAT=1, i_req=4'b0101 -> grants alternate 0,2,0,2 with one beat each.

Source files
------------

// File: rtl/arbitro_mux_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter and output multiplexer.
package arbitro_mux_4_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  localparam int unsigned MaxBeatDefault = 8;
  // Reset pointer of 3 makes requester 0 the first candidate searched.
  localparam logic [1:0] PtrReset = 2'd3;

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arbitro_mux_4_if.sv
// Requester/consumer bundle of the arbiter: requests, per-channel data, and the selected output.
interface arbitro_mux_4_if #(
  parameter int unsigned n = 4
);
  logic [3:0]   i_req;
  logic [n-1:0] i_Datos_0;
  logic [n-1:0] i_Datos_1;
  logic [n-1:0] i_Datos_2;
  logic [n-1:0] i_Datos_3;
  logic         i_ready;
  logic [3:0]   o_gnt;
  logic [1:0]   o_sel;
  logic [n-1:0] o_Datos;
  logic         o_valid;
  logic [3:0]   o_ack;

  modport master (
    output i_req, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_ready,
    input  o_gnt, o_sel, o_Datos, o_valid, o_ack
  );

  modport slave (
    input  i_req, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_ready,
    output o_gnt, o_sel, o_Datos, o_valid, o_ack
  );
endinterface

// File: rtl/arbitro_mux_4_rr_prioridad_4.sv
// Combinational round-robin pick: first set request bit searching ptr+1, ptr+2, ptr+3, ptr.
module rr_prioridad_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      // k = 4 wraps to ptr itself, so the last winner has lowest priority.
      if (!found && req[2'(ptr + 2'(k))]) begin
        idx   = 2'(ptr + 2'(k));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux_4.sv
// Round-robin arbiter for four requesters with burst-limited grants and a shared 4:1 data selector.
module arbitro_mux_4
  import arbitro_mux_4_pkg::*;
#(
  parameter int unsigned n        = 4,
  parameter int unsigned MAX_BEAT = MaxBeatDefault
) (
  input logic             i_clk,
  input logic             i_rst,
  arbitro_mux_4_if.slave  bus
);

  localparam logic [3:0] BeatLimit = 4'(MAX_BEAT);

  state_e       state_q, state_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   win_idx;
  logic         win_found;
  logic [n-1:0] datos_sel;
  logic         valid;
  logic         xfer;

  rr_prioridad_4 u_rr (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    case (sel_q)
      2'd0:    datos_sel = bus.i_Datos_0;
      2'd1:    datos_sel = bus.i_Datos_1;
      2'd2:    datos_sel = bus.i_Datos_2;
      default: datos_sel = bus.i_Datos_3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid   = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          sel_d   = win_idx;
          gnt_d   = one_hot(win_idx);
          ptr_d   = win_idx;
          cnt_d   = 4'd0;
        end
      end
      StGrant: begin
        valid = bus.i_req[sel_q];
        xfer  = valid && bus.i_ready;
        if (xfer) begin
          if (cnt_q + 4'd1 == BeatLimit) begin
            state_d = StIdle;
            gnt_d   = 4'd0;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (!valid) begin
          state_d = StIdle;
          gnt_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
    endcase
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_valid = valid;
  // A beat never completes while reset is asserted.
  assign bus.o_ack   = (xfer && !i_rst) ? one_hot(sel_q) : 4'd0;
  assign bus.o_Datos = (state_q == StGrant) ? datos_sel : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      ptr_q   <= PtrReset;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
